decoder_n_seq: RTL and testbench
================================

// Module: decoder_n_seq
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder. It generalises the 2-to-4 decoder family.
//  Adds a valid/ready output stage and a self-timed scan mode, which walks a single active line
//  up or down across all outputs. Used for row/column strobing and as a selectable decoder source
//  behind the decoder top-level wrapper.
// PARAMETERS
//  N           2   input code width; output width OUT_W = 2**N (N = 1..6)
//  ACTIVE_LOW  0   1: active output line is 0 and inactive lines are 1
//  SCAN_DIV    4   clk cycles per scan step (>=1)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active low
//  mode       in   2      00 direct, 01 scan-up, 10 scan-down, 11 hold
//  en         in   1      direct mode: 0 makes accepted word decode to all-inactive
//  in_valid   in   1      a is valid (direct mode only)
//  in_ready   out  1      block accepts a this cycle
//  a          in   N      code to decode
//  out_valid  out  1      b/idx hold a decoded word
//  out_ready  in   1      consumer takes b this cycle
//  b          out  OUT_W  one-hot (or one-cold) decoded output
//  idx        out  N      binary index of the active line in b
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): b=all-inactive, idx=0, out_valid=0, scan divider cnt=0.
//   - all-inactive: 0s if ACTIVE_LOW=0, 1s if ACTIVE_LOW=1.
//   - Reset mid-transfer drops any pending word. No handshake completes in a reset cycle.
//  Output slot: single register; free = !out_valid || out_ready.
//   - While out_valid=1 and out_ready=0, b and idx are held stable.
//   - out_valid falls after a handshake only if no new word is loaded in the same cycle.
//  Direct mode (00):
//   - in_ready = free, combinational, and no dependence on in_valid.
//   - Accept when in_valid && in_ready. Next cycle: out_valid=1, idx=a,
//     b = onehot(a), or all-inactive if en=0. Latency 1 clk; full throughput.
//   - Simultaneous output handshake and input accept: new word replaces old, out_valid stays 1.
//   - cnt held at 0.
//  Scan modes (01 up, 10 down):
//   - in_ready=0; a, in_valid and en ignored.
//   - cnt counts 0..SCAN_DIV-1.
//   - At cnt==SCAN_DIV-1 with free=1: step idx (+1 up / -1 down) and wrap modulo OUT_W
//     (OUT_W-1 -> 0 up, 0 -> OUT_W-1 down). Load b=onehot(new idx), out_valid=1, cnt=0.
//   - At terminal count with free=0: cnt holds at SCAN_DIV-1 (stall), idx unchanged.
//   - SCAN_DIV=1: one step per free cycle.
//  Hold mode (11): in_ready=0; no new words; a pending word stays until accepted; cnt held.
//  Mode change: new mode is sampled each cycle.
//   - cnt clears to 0 on any cycle where mode differs from the previous cycle's mode.
//   - idx is retained, so scan resumes from the last decoded index (direct or scan).
//   - A pending output word is never altered by a mode change.
//  Invariant: when out_valid=1 and the word came from a scan step or from en=1, exactly one b bit
//   is active and it sits at position idx.
// TESTING
//  T1 N=2, direct: a=0..3 with en=1, out_ready=1 -> b=0001,0010,0100,1000 one clk later, idx=a.
//  T2 N=2, direct: en=0, a=2 -> out_valid=1, b=0000. With ACTIVE_LOW=1: a=1, en=1 -> b=1101.
//  T3 Backpressure: out_ready=0 after one accept -> in_ready=0, b held. Raise out_ready with
//     in_valid=1 -> new word loaded in the same cycle, out_valid stays 1.
//  T4 N=3, SCAN_DIV=4, scan-up from idx=6, out_ready=1 -> b=0x80 then 0x01 (wrap), 4 clk apart.
//     Scan-down from idx=0 -> b=0x80.
//  T5 Scan with out_ready=0 for 10 clk -> idx frozen, cnt stuck at 3.
//     Release out_ready -> next step on the following edge.
//  T6 rst_n=0 for 1 clk mid-scan with out_valid=1 -> b=0, idx=0, out_valid=0, cnt=0;
//     scan restarts from idx 0.

Source files
------------

// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with a valid/ready output slot
// and a self-timed scan mode that walks the active line up or down across all outputs.
module decoder_n_seq #(
  parameter int N          = 2,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int SCAN_DIV   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [(2**N)-1:0]  b,
  output logic [N-1:0]       idx
);

  localparam int OUT_W = 2**N;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] MODE_DIRECT    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q;
  logic             free, mode_changed, is_scan, accept, step;
  logic [N-1:0]     scan_idx;

  function automatic logic [OUT_W-1:0] decode(input logic [N-1:0] code);
    logic [OUT_W-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh ^ INACTIVE;
  endfunction

  assign free         = !out_valid || out_ready;
  assign mode_changed = (mode != mode_q);
  assign is_scan      = (mode == MODE_SCAN_UP) || (mode == MODE_SCAN_DOWN);
  assign in_ready     = (mode == MODE_DIRECT) && free;
  assign accept       = in_valid && in_ready;
  // A step needs a full divider period in an unchanged scan mode and a free slot.
  assign step         = is_scan && !mode_changed && (cnt_q == CNT_LAST) && free;
  // N-bit arithmetic wraps modulo OUT_W in both directions.
  assign scan_idx     = (mode == MODE_SCAN_UP) ? idx + 1'b1 : idx - 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (mode_changed || mode == MODE_DIRECT) begin
      cnt_d = '0;
    end else if (is_scan) begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
      else if (free)         cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b         <= INACTIVE;
      idx       <= '0;
      out_valid <= 1'b0;
      cnt_q     <= '0;
      // Seeding with the live mode means leaving reset is not seen as a mode change.
      mode_q    <= mode;
    end else begin
      mode_q    <= mode;
      cnt_q     <= cnt_d;
      out_valid <= accept || step || (out_valid && !out_ready);
      if (accept) begin
        b   <= en ? decode(a) : INACTIVE;
        idx <= a;
      end else if (step) begin
        b   <= decode(scan_idx);
        idx <= scan_idx;
      end
    end
  end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Self-checking bench for decoder_n_seq: three configurations driven in lockstep,
// checked every cycle against an arithmetic model plus hand-computed literal points.
module tb_decoder_n_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, in_valid, out_ready;
  logic [1:0] mode;
  logic [2:0] a;

  logic       rdy2, rdy2l, rdy3, ov2, ov2l, ov3;
  logic [3:0] b2, b2l;
  logic [7:0] b3;
  logic [1:0] idx2, idx2l;
  logic [2:0] idx3;

  decoder_n_seq #(.N(2), .ACTIVE_LOW(1'b0), .SCAN_DIV(1)) u_n2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .in_valid(in_valid), .in_ready(rdy2),
    .a(a[1:0]), .out_valid(ov2), .out_ready(out_ready), .b(b2), .idx(idx2));

  decoder_n_seq #(.N(2), .ACTIVE_LOW(1'b1), .SCAN_DIV(2)) u_n2l (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .in_valid(in_valid), .in_ready(rdy2l),
    .a(a[1:0]), .out_valid(ov2l), .out_ready(out_ready), .b(b2l), .idx(idx2l));

  decoder_n_seq #(.N(3), .ACTIVE_LOW(1'b0), .SCAN_DIV(4)) u_n3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .in_valid(in_valid), .in_ready(rdy3),
    .a(a), .out_valid(ov3), .out_ready(out_ready), .b(b3), .idx(idx3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-instance configuration and DUT views, index 0..2 = u_n2, u_n2l, u_n3.
  int ow_p[3]  = '{4, 4, 8};
  bit al_p[3]  = '{1'b0, 1'b1, 1'b0};
  int div_p[3] = '{1, 2, 4};

  logic [7:0] d_b[3];
  int         d_idx[3];
  logic       d_ov[3], d_rdy[3];
  assign d_b[0] = {4'b0, b2};  assign d_b[1] = {4'b0, b2l};  assign d_b[2] = b3;
  assign d_idx[0] = int'(idx2); assign d_idx[1] = int'(idx2l); assign d_idx[2] = int'(idx3);
  assign d_ov[0] = ov2;  assign d_ov[1] = ov2l;  assign d_ov[2] = ov3;
  assign d_rdy[0] = rdy2; assign d_rdy[1] = rdy2l; assign d_rdy[2] = rdy3;

  // Model state: what the output slot and scan divider must hold after each edge.
  logic [7:0] m_b[3];
  int         m_idx[3], m_cnt[3];
  bit         m_ov[3];
  logic [1:0] m_pm[3];
  bit         model_ok = 1'b0;
  bit         f_free, f_chg, f_load;

  function automatic logic [7:0] lines(input int i, input int k, input bit active);
    logic [7:0] on, mask;
    mask = 8'((1 << ow_p[i]) - 1);
    on   = active ? 8'(1 << k) : 8'h00;
    return al_p[i] ? (on ^ mask) : on;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_b[i] = lines(i, 0, 1'b0); m_idx[i] = 0; m_ov[i] = 1'b0; m_cnt[i] = 0; m_pm[i] = mode;
      end else begin
        f_free = !m_ov[i] || out_ready;
        f_chg  = (mode != m_pm[i]);
        m_pm[i] = mode;
        f_load = 1'b0;
        if (mode == 2'd0) begin
          m_cnt[i] = 0;
          if (in_valid && f_free) begin
            m_idx[i] = int'(a) % ow_p[i];
            m_b[i]   = lines(i, m_idx[i], en);
            f_load   = 1'b1;
          end
        end else if (f_chg) begin
          m_cnt[i] = 0;
        end else if (mode != 2'd3) begin
          if (m_cnt[i] < div_p[i] - 1) m_cnt[i]++;
          else if (f_free) begin
            m_idx[i] = (mode == 2'd1) ? (m_idx[i] + 1) % ow_p[i] : (m_idx[i] + ow_p[i] - 1) % ow_p[i];
            m_b[i]   = lines(i, m_idx[i], 1'b1);
            m_cnt[i] = 0;
            f_load   = 1'b1;
          end
        end
        if (f_load) m_ov[i] = 1'b1;
        else if (m_ov[i] && out_ready) m_ov[i] = 1'b0;
      end
    end
    if (!rst_n) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("inst%0d b", i), 32'(d_b[i]), 32'(m_b[i]));
        check($sformatf("inst%0d idx", i), 32'(d_idx[i]), 32'(m_idx[i]));
        check($sformatf("inst%0d out_valid", i), 32'(d_ov[i]), 32'(m_ov[i]));
        check($sformatf("inst%0d in_ready", i), 32'(d_rdy[i]),
              32'((mode == 2'd0) && (!m_ov[i] || out_ready)));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] t1_exp[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst_n = 1'b0; mode = 2'b00; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
    tick(2);
    check("reset b", 32'(b2), 32'h0);
    check("reset b active-low", 32'(b2l), 32'hF);
    check("reset out_valid", 32'(ov3), 32'h0);
    rst_n = 1'b1;

    // Direct decode of every code, one word per clock.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 3'(k);
      tick();
      check("t1 b", 32'(b2), 32'(t1_exp[k]));
      check("t1 idx", 32'(idx2), k);
    end

    en = 1'b0; a = 3'd2;
    tick();
    check("t2 en=0 b", 32'(b2), 32'h0);
    check("t2 en=0 out_valid", 32'(ov2), 32'h1);
    en = 1'b1; a = 3'd1;
    tick();
    check("t2 active-low b", 32'(b2l), 32'hD);

    // Backpressure: hold a word, then refill in the same cycle as the handshake.
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; a = 3'd3; out_ready = 1'b0;
    tick();
    a = 3'd0;
    #1;
    check("t3 in_ready blocked", 32'(rdy2), 32'h0);
    tick(3);
    check("t3 b held", 32'(b2), 32'h8);
    out_ready = 1'b1;
    tick();
    check("t3 reload b", 32'(b2), 32'h1);
    check("t3 out_valid stays", 32'(ov2), 32'h1);

    // Scan up from 6 with wrap, then down from 0.
    a = 3'd6;
    tick();
    check("t4 seed idx", 32'(idx3), 32'h6);
    in_valid = 1'b0; mode = 2'b01;
    tick(5);
    check("t4 up b", 32'(b3), 32'h80);
    tick(4);
    check("t4 wrap b", 32'(b3), 32'h01);
    check("t4 wrap idx", 32'(idx3), 32'h0);
    mode = 2'b10;
    tick(5);
    check("t4 down wrap b", 32'(b3), 32'h80);
    check("t4 down idx", 32'(idx3), 32'h7);

    // Stall under backpressure, step on the edge after release.
    mode = 2'b01; out_ready = 1'b0;
    tick(10);
    check("t5 frozen idx", 32'(idx3), 32'h7);
    out_ready = 1'b1;
    tick();
    check("t5 release b", 32'(b3), 32'h01);

    // Reset mid-scan with a pending word, then restart from index 0.
    out_ready = 1'b0;
    tick(4);
    check("t6 pending", 32'(ov3), 32'h1);
    rst_n = 1'b0;
    tick();
    check("t6 reset b", 32'(b3), 32'h0);
    check("t6 reset idx", 32'(idx3), 32'h0);
    check("t6 reset out_valid", 32'(ov3), 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick(3);
    check("t6 no step yet", 32'(ov3), 32'h0);
    tick();
    check("t6 restart b", 32'(b3), 32'h02);

    // Hold mode keeps a pending word until taken.
    out_ready = 1'b0; mode = 2'b11;
    tick(3);
    check("hold b", 32'(b3), 32'h02);
    out_ready = 1'b1;
    tick();
    check("hold drained", 32'(ov3), 32'h0);
    mode = 2'b00;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
